// File: rtl/execute_pkg.sv
// Shared constants, ALU function codes and FSM encodings for the riscx EX stage.
package execute_pkg;

    localparam int XLEN          = 32;
    localparam int PC_WIDTH      = 32;
    localparam int INSTR_WIDTH   = 32;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [3:0] ALU_FUN_ADD  = 4'd0;
    localparam logic [3:0] ALU_FUN_SUB  = 4'd1;
    localparam logic [3:0] ALU_FUN_SLL  = 4'd2;
    localparam logic [3:0] ALU_FUN_SLT  = 4'd3;
    localparam logic [3:0] ALU_FUN_SLTU = 4'd4;
    localparam logic [3:0] ALU_FUN_XOR  = 4'd5;
    localparam logic [3:0] ALU_FUN_SRL  = 4'd6;
    localparam logic [3:0] ALU_FUN_SRA  = 4'd7;
    localparam logic [3:0] ALU_FUN_OR   = 4'd8;
    localparam logic [3:0] ALU_FUN_AND  = 4'd9;
    localparam logic [3:0] ALU_FUN_MUL  = 4'd10;
    localparam logic [3:0] ALU_FUN_DIVU = 4'd11;
    localparam logic [3:0] ALU_FUN_REMU = 4'd12;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'd0,
        MDU_DIVU = 2'd1,
        MDU_REMU = 2'd2
    } mdu_op_e;

    function automatic logic is_mdu_fun(input logic [3:0] fun);
        return (fun == ALU_FUN_MUL) || (fun == ALU_FUN_DIVU) || (fun == ALU_FUN_REMU);
    endfunction

    function automatic mdu_op_e mdu_op_of(input logic [3:0] fun);
        case (fun)
            ALU_FUN_DIVU: return MDU_DIVU;
            ALU_FUN_REMU: return MDU_REMU;
            default:      return MDU_MUL;
        endcase
    endfunction

endpackage

// File: rtl/execute_mdu.sv
// Iterative multiply / unsigned divide unit: one shift-add or restoring-divide step per clock.
module execute_mdu
    import execute_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         start_i,
    input  mdu_op_e      op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o
);

    ex_state_e    state_q;
    mdu_op_e      op_q;
    logic [5:0]   cnt_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] opA_q;
    logic [W-1:0] opB_q;

    logic [W-1:0] mulSum;
    logic [W:0]   remShift;
    logic [W:0]   remTrial;

    // acc holds the product (MUL) or partial remainder (DIV); opA doubles as the quotient shift register.
    always_comb begin
        mulSum   = opB_q[0] ? (acc_q + opA_q) : acc_q;
        remShift = {acc_q, opA_q[W-1]};
        remTrial = remShift - {1'b0, opB_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EX_IDLE;
            op_q    <= MDU_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
        end else if (flush_i) begin
            state_q <= EX_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (start_i) begin
                        state_q <= EX_BUSY;
                        op_q    <= op_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        opA_q   <= a_i;
                        opB_q   <= b_i;
                    end
                end
                EX_BUSY: begin
                    if (op_q == MDU_MUL) begin
                        acc_q <= mulSum;
                        opA_q <= opA_q << 1;
                        opB_q <= opB_q >> 1;
                    end else if (remTrial[W]) begin
                        acc_q <= remShift[W-1:0];
                        opA_q <= {opA_q[W-2:0], 1'b0};
                    end else begin
                        acc_q <= remTrial[W-1:0];
                        opA_q <= {opA_q[W-2:0], 1'b1};
                    end
                    if (cnt_q == 6'(W - 1)) begin
                        state_q <= EX_DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                EX_DONE: begin
                    if (!hold_i) begin
                        state_q <= EX_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= EX_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o   = (state_q == EX_BUSY);
    assign done_o   = (state_q == EX_DONE);
    assign result_o = (op_q == MDU_DIVU) ? opA_q : acc_q;

endmodule

// File: rtl/execute.sv
// riscx EX stage: single-cycle ALU, iterative MDU, stall/flush control and the EX/MEM register.
module execute
    import execute_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_ex_valid_i,
    input  logic [PC_WIDTH-1:0]      id_ex_pc_i,
    input  logic [INSTR_WIDTH-1:0]   id_ex_instr_i,
    input  logic [XLEN-1:0]          id_ex_alu_op1_i,
    input  logic [XLEN-1:0]          id_ex_alu_op2_i,
    input  logic [3:0]               id_ex_alu_fun_i,
    input  logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx_i,
    input  logic                     id_ex_rd_en_i,
    input  logic                     flush_i,
    input  logic                     mem_stall_i,
    output logic                     ex_stall_o,
    output logic                     ex_mem_valid_o,
    output logic [PC_WIDTH-1:0]      ex_mem_pc_o,
    output logic [INSTR_WIDTH-1:0]   ex_mem_instr_o,
    output logic [XLEN-1:0]          ex_mem_result_o,
    output logic [REG_IDX_WIDTH-1:0] ex_mem_rd_idx_o,
    output logic                     ex_mem_rd_en_o
);

    logic                     isMdu;
    logic                     mduStart;
    logic                     mduBusy;
    logic                     mduDone;
    logic [XLEN-1:0]          mduResult;
    logic [XLEN-1:0]          aluResult;
    logic [4:0]               shamt;

    logic                     valid_q;
    logic [PC_WIDTH-1:0]      pc_q;
    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [XLEN-1:0]          result_q;
    logic [REG_IDX_WIDTH-1:0] rdIdx_q;
    logic                     rdEn_q;

    assign isMdu    = id_ex_valid_i && is_mdu_fun(id_ex_alu_fun_i);
    assign mduStart = isMdu && !mduBusy && !mduDone && !flush_i;
    assign ex_stall_o = rst_n && !flush_i && id_ex_valid_i
                      && ((isMdu && !mduDone) || mem_stall_i);

    execute_mdu #(.W(XLEN)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .hold_i   (mem_stall_i),
        .start_i  (mduStart),
        .op_i     (mdu_op_of(id_ex_alu_fun_i)),
        .a_i      (id_ex_alu_op1_i),
        .b_i      (id_ex_alu_op2_i),
        .busy_o   (mduBusy),
        .done_o   (mduDone),
        .result_o (mduResult)
    );

    assign shamt = id_ex_alu_op2_i[4:0];

    always_comb begin
        aluResult = '0;
        case (id_ex_alu_fun_i)
            ALU_FUN_ADD:  aluResult = id_ex_alu_op1_i + id_ex_alu_op2_i;
            ALU_FUN_SUB:  aluResult = id_ex_alu_op1_i - id_ex_alu_op2_i;
            ALU_FUN_SLL:  aluResult = id_ex_alu_op1_i << shamt;
            ALU_FUN_SLT:  aluResult = {{(XLEN-1){1'b0}},
                                       $signed(id_ex_alu_op1_i) < $signed(id_ex_alu_op2_i)};
            ALU_FUN_SLTU: aluResult = {{(XLEN-1){1'b0}}, id_ex_alu_op1_i < id_ex_alu_op2_i};
            ALU_FUN_XOR:  aluResult = id_ex_alu_op1_i ^ id_ex_alu_op2_i;
            ALU_FUN_SRL:  aluResult = id_ex_alu_op1_i >> shamt;
            ALU_FUN_SRA:  aluResult = $unsigned($signed(id_ex_alu_op1_i) >>> shamt);
            ALU_FUN_OR:   aluResult = id_ex_alu_op1_i | id_ex_alu_op2_i;
            ALU_FUN_AND:  aluResult = id_ex_alu_op1_i & id_ex_alu_op2_i;
            default:      aluResult = '0;
        endcase
    end

    // A multi-cycle op not yet in DONE leaves a bubble; flush beats mem_stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            result_q <= '0;
            rdIdx_q  <= '0;
            rdEn_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            rdEn_q  <= 1'b0;
        end else if (!mem_stall_i) begin
            if (!id_ex_valid_i || (isMdu && !mduDone)) begin
                valid_q <= 1'b0;
                rdEn_q  <= 1'b0;
            end else begin
                valid_q  <= 1'b1;
                pc_q     <= id_ex_pc_i;
                instr_q  <= id_ex_instr_i;
                result_q <= isMdu ? mduResult : aluResult;
                rdIdx_q  <= id_ex_rd_idx_i;
                rdEn_q   <= id_ex_rd_en_i;
            end
        end
    end

    assign ex_mem_valid_o  = valid_q;
    assign ex_mem_pc_o     = pc_q;
    assign ex_mem_instr_o  = instr_q;
    assign ex_mem_result_o = result_q;
    assign ex_mem_rd_idx_o = rdIdx_q;
    assign ex_mem_rd_en_o  = rdEn_q;

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage: ALU ops, MDU latency/results, flush, reset, mem stall.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ex_valid_i;
    logic [31:0] id_ex_pc_i;
    logic [31:0] id_ex_instr_i;
    logic [31:0] id_ex_alu_op1_i;
    logic [31:0] id_ex_alu_op2_i;
    logic [3:0]  id_ex_alu_fun_i;
    logic [4:0]  id_ex_rd_idx_i;
    logic        id_ex_rd_en_i;
    logic        flush_i;
    logic        mem_stall_i;
    logic        ex_stall_o;
    logic        ex_mem_valid_o;
    logic [31:0] ex_mem_pc_o;
    logic [31:0] ex_mem_instr_o;
    logic [31:0] ex_mem_result_o;
    logic [4:0]  ex_mem_rd_idx_o;
    logic        ex_mem_rd_en_o;

    int checks = 0;
    int errors = 0;

    execute dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_ex_valid_i   (id_ex_valid_i),
        .id_ex_pc_i      (id_ex_pc_i),
        .id_ex_instr_i   (id_ex_instr_i),
        .id_ex_alu_op1_i (id_ex_alu_op1_i),
        .id_ex_alu_op2_i (id_ex_alu_op2_i),
        .id_ex_alu_fun_i (id_ex_alu_fun_i),
        .id_ex_rd_idx_i  (id_ex_rd_idx_i),
        .id_ex_rd_en_i   (id_ex_rd_en_i),
        .flush_i         (flush_i),
        .mem_stall_i     (mem_stall_i),
        .ex_stall_o      (ex_stall_o),
        .ex_mem_valid_o  (ex_mem_valid_o),
        .ex_mem_pc_o     (ex_mem_pc_o),
        .ex_mem_instr_o  (ex_mem_instr_o),
        .ex_mem_result_o (ex_mem_result_o),
        .ex_mem_rd_idx_o (ex_mem_rd_idx_o),
        .ex_mem_rd_en_o  (ex_mem_rd_en_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc);
        id_ex_valid_i   = 1'b1;
        id_ex_alu_fun_i = fun;
        id_ex_alu_op1_i = a;
        id_ex_alu_op2_i = b;
        id_ex_rd_idx_i  = rd;
        id_ex_rd_en_i   = 1'b1;
        id_ex_pc_i      = pc;
        id_ex_instr_i   = pc ^ 32'h0000_0013;
    endtask

    // Presents one MDU op, counts stalled cycles, and returns what lands in ex_mem.
    task automatic run_mdu(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int n, output logic bubbleOk,
                           output logic validOut);
        drive(fun, a, b, 5'd9, 32'h0000_2000);
        #1;
        n = 0;
        bubbleOk = 1'b1;
        while (ex_stall_o && n < 100) begin
            tick;
            n++;
            if (ex_mem_valid_o !== 1'b0) bubbleOk = 1'b0;
        end
        tick;
        res = ex_mem_result_o;
        validOut = ex_mem_valid_o;
        id_ex_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush_i = 1'b0;
        mem_stall_i = 1'b0;
        drive(ALU_FUN_MUL, 32'd3, 32'd4, 5'd1, 32'h10);
        tick;
        tick;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 0", ex_stall_o);
        end
        checks++;
        if ({ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_result_o, ex_mem_pc_o} !== 66'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b en=%b res=%h pc=%h expected all 0",
                     ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_result_o, ex_mem_pc_o);
        end
        id_ex_valid_i = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_alu;
        logic [3:0]  funT [11] = '{ALU_FUN_ADD, ALU_FUN_SUB, ALU_FUN_SRA, ALU_FUN_SLT, ALU_FUN_SLTU,
                                   ALU_FUN_SLL, ALU_FUN_SRL, ALU_FUN_XOR, ALU_FUN_OR, ALU_FUN_AND, 4'd13};
        logic [31:0] aT [11] = '{32'd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd1, 32'h8000_0000, 32'h0000_F0F0, 32'h0000_F000, 32'h0000_FF00, 32'd5};
        logic [31:0] bT [11] = '{32'd7, 32'd1, 32'd4, 32'd1, 32'd1,
                                 32'd33, 32'd4, 32'h0000_00FF, 32'h0000_000F, 32'h0000_0FF0, 32'd7};
        logic [31:0] eT [11] = '{32'h0000_000C, 32'hFFFF_FFFF, 32'hF800_0000, 32'd1, 32'd0,
                                 32'd2, 32'h0800_0000, 32'h0000_F00F, 32'h0000_F00F, 32'h0000_0F00, 32'd0};
        for (int i = 0; i < 11; i++) begin
            drive(funT[i], aT[i], bT[i], 5'(i + 1), 32'h1000 + 32'(4 * i));
            #1;
            checks++;
            if (ex_stall_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL alu_stall[%0d]: got %b expected 0", i, ex_stall_o);
            end
            tick;
            checks++;
            if (ex_mem_result_o !== eT[i]) begin
                errors++;
                $display("[TB] FAIL alu_result[%0d]: got %h expected %h", i, ex_mem_result_o, eT[i]);
            end
            checks++;
            if ({ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_rd_idx_o, ex_mem_pc_o}
                !== {1'b1, 1'b1, 5'(i + 1), 32'h1000 + 32'(4 * i)}) begin
                errors++;
                $display("[TB] FAIL alu_meta[%0d]: got v=%b en=%b rd=%0d pc=%h expected v=1 en=1 rd=%0d pc=%h",
                         i, ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_rd_idx_o, ex_mem_pc_o,
                         i + 1, 32'h1000 + 32'(4 * i));
            end
        end
        id_ex_valid_i = 1'b0;
        tick;
        checks++;
        if ({ex_mem_valid_o, ex_mem_rd_en_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL invalid_slot: got v=%b en=%b expected 0 0", ex_mem_valid_o, ex_mem_rd_en_o);
        end
    endtask

    task automatic test_mul;
        logic [31:0] res;
        int          n;
        logic        bubbleOk;
        logic        validOut;
        run_mdu(ALU_FUN_MUL, 32'h0001_2345, 32'h0000_0010, res, n, bubbleOk, validOut);
        checks++;
        if (n != 33) begin
            errors++;
            $display("[TB] FAIL mul_stall_cycles: got %0d expected 33", n);
        end
        checks++;
        if (bubbleOk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mul_bubble: got valid during busy expected 0");
        end
        checks++;
        if (res !== 32'h0012_3450 || validOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mul_result: got %h v=%b expected 00123450 v=1", res, validOut);
        end
    endtask

    task automatic test_div;
        logic [3:0]  funT [4] = '{ALU_FUN_DIVU, ALU_FUN_REMU, ALU_FUN_DIVU, ALU_FUN_REMU};
        logic [31:0] aT   [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] bT   [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] eT   [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] res;
        int          n;
        logic        bubbleOk;
        logic        validOut;
        for (int i = 0; i < 4; i++) begin
            run_mdu(funT[i], aT[i], bT[i], res, n, bubbleOk, validOut);
            checks++;
            if (res !== eT[i] || validOut !== 1'b1 || n != 33) begin
                errors++;
                $display("[TB] FAIL div[%0d]: got %h v=%b stalls=%0d expected %h v=1 stalls=33",
                         i, res, validOut, n, eT[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int          n;
        logic        bubbleOk;
        logic        validOut;
        run_mdu(ALU_FUN_MUL, 32'd3, 32'd4, res, n, bubbleOk, validOut);
        checks++;
        if (res !== 32'd12) begin
            errors++;
            $display("[TB] FAIL b2b_mul: got %h expected 0000000c", res);
        end
        drive(ALU_FUN_ADD, 32'd1, 32'd2, 5'd4, 32'h3000);
        #1;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_stall: got %b expected 0", ex_stall_o);
        end
        tick;
        checks++;
        if (ex_mem_result_o !== 32'd3 || ex_mem_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_add: got %h v=%b expected 00000003 v=1", ex_mem_result_o, ex_mem_valid_o);
        end
        id_ex_valid_i = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] res;
        int          n;
        logic        bubbleOk;
        logic        validOut;
        drive(ALU_FUN_MUL, 32'd9, 32'd9, 5'd2, 32'h4000);
        #1;
        repeat (5) tick;
        flush_i = 1'b1;
        #1;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall: got %b expected 0", ex_stall_o);
        end
        tick;
        flush_i = 1'b0;
        id_ex_valid_i = 1'b0;
        checks++;
        if (ex_mem_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_valid: got %b expected 0", ex_mem_valid_o);
        end
        run_mdu(ALU_FUN_MUL, 32'd9, 32'd9, res, n, bubbleOk, validOut);
        checks++;
        if (res !== 32'd81 || n != 33) begin
            errors++;
            $display("[TB] FAIL flush_restart: got %h stalls=%0d expected 00000051 stalls=33", res, n);
        end
        drive(ALU_FUN_ADD, 32'd2, 32'd2, 5'd6, 32'h4100);
        tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        id_ex_valid_i = 1'b0;
        checks++;
        if ({ex_mem_valid_o, ex_mem_rd_en_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_alu: got v=%b en=%b expected 0 0", ex_mem_valid_o, ex_mem_rd_en_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int          n;
        logic        bubbleOk;
        logic        validOut;
        drive(ALU_FUN_ADD, 32'd40, 32'd2, 5'd7, 32'h5000);
        tick;
        drive(ALU_FUN_DIVU, 32'd1000, 32'd3, 5'd8, 32'h5004);
        #1;
        repeat (10) tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_stall: got %b expected 0", ex_stall_o);
        end
        tick;
        checks++;
        if ({ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_rd_idx_o, ex_mem_result_o, ex_mem_pc_o, ex_mem_instr_o}
            !== 103'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got v=%b en=%b rd=%0d res=%h pc=%h instr=%h expected all 0",
                     ex_mem_valid_o, ex_mem_rd_en_o, ex_mem_rd_idx_o, ex_mem_result_o,
                     ex_mem_pc_o, ex_mem_instr_o);
        end
        rst_n = 1'b1;
        id_ex_valid_i = 1'b0;
        tick;
        run_mdu(ALU_FUN_DIVU, 32'd1000, 32'd3, res, n, bubbleOk, validOut);
        checks++;
        if (res !== 32'd333 || n != 33) begin
            errors++;
            $display("[TB] FAIL rstmid_restart: got %h stalls=%0d expected 0000014d stalls=33", res, n);
        end
    endtask

    task automatic test_mem_stall;
        drive(ALU_FUN_MUL, 32'd7, 32'd6, 5'd10, 32'h6000);
        #1;
        repeat (33) tick;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mstall_done_stall: got %b expected 0", ex_stall_o);
        end
        mem_stall_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ex_stall_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mstall_stall[%0d]: got %b expected 1", i, ex_stall_o);
            end
            tick;
            checks++;
            if (ex_mem_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mstall_hold[%0d]: got v=%b expected 0", i, ex_mem_valid_o);
            end
        end
        mem_stall_i = 1'b0;
        #1;
        checks++;
        if (ex_stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mstall_release: got %b expected 0", ex_stall_o);
        end
        tick;
        id_ex_valid_i = 1'b0;
        checks++;
        if (ex_mem_result_o !== 32'd42 || ex_mem_valid_o !== 1'b1 || ex_mem_rd_idx_o !== 5'd10) begin
            errors++;
            $display("[TB] FAIL mstall_result: got %h v=%b rd=%0d expected 0000002a v=1 rd=10",
                     ex_mem_result_o, ex_mem_valid_o, ex_mem_rd_idx_o);
        end
        tick;
        checks++;
        if (ex_mem_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mstall_once: got v=%b expected 0", ex_mem_valid_o);
        end
    endtask

    initial begin
        $display("[TB] starting execute bench");
        test_reset;
        test_alu;
        test_mul;
        test_div;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_mem_stall;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
